// File: rtl/vdp_pkg.sv
// Shared definitions for the MSX VDP CPU port controller: register indices,
// display modes, status bit positions, control-byte opcodes and FSM states.
package vdp_pkg;

    localparam int TBL_W = 14;

    localparam int REG_R0 = 0;
    localparam int REG_R1 = 1;
    localparam int REG_R2 = 2;
    localparam int REG_R3 = 3;
    localparam int REG_R4 = 4;
    localparam int REG_R5 = 5;
    localparam int REG_R6 = 6;
    localparam int REG_R7 = 7;

    localparam int ST_F   = 7;
    localparam int ST_5S  = 6;
    localparam int ST_C   = 5;
    localparam int R1_IE  = 5;

    typedef enum logic [1:0] {
        MODE_TEXT = 2'd0,
        MODE_G1   = 2'd1,
        MODE_G2   = 2'd2,
        MODE_MC   = 2'd3
    } vdp_mode_e;

    typedef enum logic [1:0] {
        OP_RDSETUP = 2'b00,
        OP_WRSETUP = 2'b01,
        OP_REGWR   = 2'b10,
        OP_IGNORE  = 2'b11
    } ctrl_op_e;

    typedef enum logic {
        LAT_FIRST,
        LAT_SECOND
    } latch_state_e;

    typedef enum logic [1:0] {
        PF_IDLE,
        PF_ISSUE,
        PF_CAPTURE
    } pf_state_e;

    typedef logic [7:0][7:0] vdp_regs_t;

endpackage

// File: rtl/vdp_cfg_decode.sv
// Combinational mapping from the VDP register file R0-R7 to the video block's
// configuration inputs (mode, table bases, colours, enables).
module vdp_cfg_decode
    import vdp_pkg::*;
(
    input  vdp_regs_t          regs_i,
    output logic [1:0]         mode_o,
    output logic [TBL_W-1:0]   name_table_addr_o,
    output logic [TBL_W-1:0]   color_table_addr_o,
    output logic [TBL_W-1:0]   font_addr_o,
    output logic [TBL_W-1:0]   sprite_attr_addr_o,
    output logic [TBL_W-1:0]   sprite_pattern_table_addr_o,
    output logic               video_on_o,
    output logic               vert_retrace_int_o,
    output logic               sprite_large_o,
    output logic               sprite_enlarged_o,
    output logic [3:0]         text_color_o,
    output logic [3:0]         back_color_o
);

    logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7;
    vdp_mode_e  mode;
    logic       unused_bits;

    assign r0 = regs_i[REG_R0];
    assign r1 = regs_i[REG_R1];
    assign r2 = regs_i[REG_R2];
    assign r3 = regs_i[REG_R3];
    assign r4 = regs_i[REG_R4];
    assign r5 = regs_i[REG_R5];
    assign r6 = regs_i[REG_R6];
    assign r7 = regs_i[REG_R7];

    // Text mode bit overrides the graphics II bit, which overrides multicolour.
    always_comb begin
        mode = MODE_G1;
        if (r1[4])      mode = MODE_TEXT;
        else if (r0[1]) mode = MODE_G2;
        else if (r1[3]) mode = MODE_MC;
    end

    assign mode_o                      = mode;
    assign name_table_addr_o           = {r2[3:0], 10'b0};
    assign color_table_addr_o          = (mode == MODE_G2) ? {r3[7], 13'b0} : {r3, 6'b0};
    assign font_addr_o                 = (mode == MODE_G2) ? {r4[2], 13'b0} : {r4[2:0], 11'b0};
    assign sprite_attr_addr_o          = {r5[6:0], 7'b0};
    assign sprite_pattern_table_addr_o = {r6[2:0], 11'b0};
    assign video_on_o                  = r1[6];
    assign vert_retrace_int_o          = r1[5];
    assign sprite_large_o              = r1[1];
    assign sprite_enlarged_o           = r1[0];
    assign text_color_o                = r7[7:4];
    assign back_color_o                = r7[3:0];

    assign unused_bits = ^{r0[7:2], r0[0], r1[7], r1[2], r2[7:4], r4[7:3], r5[7], r6[7:3]};

endmodule

// File: rtl/vdp_port_ctrl.sv
// CPU-side port controller for the MSX VDP: control latch, register file,
// VRAM port-A sequencing with read-ahead, status register and frame interrupt.
module vdp_port_ctrl
    import vdp_pkg::*;
#(
    parameter int         ADDR_W   = 14,
    parameter logic [7:0] RESET_R1 = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               io_port_i,
    input  logic               io_wr_i,
    input  logic               io_rd_i,
    input  logic [7:0]         io_din_i,
    output logic [7:0]         io_dout_o,
    output logic [ADDR_W-1:0]  vram_addr_o,
    output logic [7:0]         vram_wdata_o,
    output logic               vram_we_o,
    output logic               vram_re_o,
    input  logic [7:0]         vram_rdata_i,
    input  logic               frame_tick_i,
    input  logic               spr_coll_in_i,
    input  logic               spr_5th_in_i,
    input  logic [4:0]         spr_5th_num_i,
    output logic [1:0]         mode_o,
    output logic [TBL_W-1:0]   name_table_addr_o,
    output logic [TBL_W-1:0]   color_table_addr_o,
    output logic [TBL_W-1:0]   font_addr_o,
    output logic [TBL_W-1:0]   sprite_attr_addr_o,
    output logic [TBL_W-1:0]   sprite_pattern_table_addr_o,
    output logic               video_on_o,
    output logic               sprite_large_o,
    output logic               sprite_enlarged_o,
    output logic               vert_retrace_int_o,
    output logic [3:0]         text_color_o,
    output logic [3:0]         back_color_o,
    output logic               n_int_o
);

    latch_state_e      lat_st_q;
    logic [7:0]        lat_q;
    vdp_regs_t         regs_q;
    logic [ADDR_W-1:0] addr_q, vram_addr_q;
    logic [7:0]        rbuf_q, io_dout_q, vram_wdata_q;
    logic              vram_we_q, vram_re_q;
    pf_state_e         pf_q;
    logic              restart_q;
    logic              f_q, c_q, s5_q;
    logic [4:0]        num5_q;

    logic              ctrl_wr, ctrl_rd, data_wr, data_rd, setup_wr;
    ctrl_op_e          op;
    logic [ADDR_W-1:0] setup_addr, addr_inc;

    assign ctrl_wr    = io_wr_i &  io_port_i;
    assign ctrl_rd    = io_rd_i &  io_port_i;
    assign data_wr    = io_wr_i & ~io_port_i;
    assign data_rd    = io_rd_i & ~io_port_i;
    assign op         = ctrl_op_e'(io_din_i[7:6]);
    assign setup_wr   = ctrl_wr && (lat_st_q == LAT_SECOND) &&
                        (op == OP_RDSETUP || op == OP_WRSETUP);
    assign setup_addr = ADDR_W'({io_din_i[5:0], lat_q});
    assign addr_inc   = addr_q + 1'b1;

    // Any address setup also drops an in-flight prefetch so its capture
    // cannot bump the freshly loaded address.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_st_q     <= LAT_FIRST;
            lat_q        <= 8'h00;
            regs_q       <= '0;
            regs_q[REG_R1] <= RESET_R1;
            addr_q       <= '0;
            vram_addr_q  <= '0;
            vram_wdata_q <= 8'h00;
            vram_we_q    <= 1'b0;
            vram_re_q    <= 1'b0;
            rbuf_q       <= 8'h00;
            pf_q         <= PF_IDLE;
            restart_q    <= 1'b0;
        end else begin
            vram_we_q <= 1'b0;
            vram_re_q <= 1'b0;

            if (data_wr || data_rd || ctrl_rd) begin
                lat_st_q <= LAT_FIRST;
            end else if (ctrl_wr) begin
                if (lat_st_q == LAT_FIRST) begin
                    lat_q    <= io_din_i;
                    lat_st_q <= LAT_SECOND;
                end else begin
                    lat_st_q <= LAT_FIRST;
                    if (op == OP_REGWR) regs_q[io_din_i[2:0]] <= lat_q;
                end
            end

            if (setup_wr) begin
                addr_q    <= setup_addr;
                restart_q <= 1'b0;
                if (op == OP_RDSETUP) begin
                    pf_q        <= PF_ISSUE;
                    vram_re_q   <= 1'b1;
                    vram_addr_q <= setup_addr;
                end else begin
                    pf_q <= PF_IDLE;
                end
            end else if (data_wr) begin
                vram_we_q    <= 1'b1;
                vram_wdata_q <= io_din_i;
                vram_addr_q  <= addr_q;
                rbuf_q       <= io_din_i;
                addr_q       <= addr_inc;
                pf_q         <= PF_IDLE;
                restart_q    <= 1'b0;
            end else begin
                case (pf_q)
                    PF_IDLE: begin
                        if (data_rd) begin
                            pf_q        <= PF_ISSUE;
                            vram_re_q   <= 1'b1;
                            vram_addr_q <= addr_q;
                        end
                    end
                    PF_ISSUE: begin
                        pf_q <= PF_CAPTURE;
                        if (data_rd) restart_q <= 1'b1;
                    end
                    PF_CAPTURE: begin
                        rbuf_q    <= vram_rdata_i;
                        addr_q    <= addr_inc;
                        restart_q <= 1'b0;
                        if (data_rd || restart_q) begin
                            pf_q        <= PF_ISSUE;
                            vram_re_q   <= 1'b1;
                            vram_addr_q <= addr_inc;
                        end else begin
                            pf_q <= PF_IDLE;
                        end
                    end
                    default: pf_q <= PF_IDLE;
                endcase
            end
        end
    end

    // Status flags: a set event in the same cycle as a status read wins over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_q       <= 1'b0;
            c_q       <= 1'b0;
            s5_q      <= 1'b0;
            num5_q    <= 5'd0;
            io_dout_q <= 8'h00;
        end else begin
            if (frame_tick_i)  f_q <= 1'b1;
            else if (ctrl_rd)  f_q <= 1'b0;

            if (spr_coll_in_i) c_q <= 1'b1;
            else if (ctrl_rd)  c_q <= 1'b0;

            if (spr_5th_in_i) begin
                s5_q <= 1'b1;
                if (!s5_q) num5_q <= spr_5th_num_i;
            end else if (ctrl_rd) begin
                s5_q <= 1'b0;
            end

            if (data_rd)      io_dout_q <= rbuf_q;
            else if (ctrl_rd) io_dout_q <= {f_q, s5_q, c_q, num5_q};
        end
    end

    assign io_dout_o    = io_dout_q;
    assign vram_addr_o  = vram_addr_q;
    assign vram_wdata_o = vram_wdata_q;
    assign vram_we_o    = vram_we_q;
    assign vram_re_o    = vram_re_q;
    assign n_int_o      = ~(f_q & regs_q[REG_R1][R1_IE]);

    vdp_cfg_decode u_cfg_decode (
        .regs_i                      (regs_q),
        .mode_o                      (mode_o),
        .name_table_addr_o           (name_table_addr_o),
        .color_table_addr_o          (color_table_addr_o),
        .font_addr_o                 (font_addr_o),
        .sprite_attr_addr_o          (sprite_attr_addr_o),
        .sprite_pattern_table_addr_o (sprite_pattern_table_addr_o),
        .video_on_o                  (video_on_o),
        .vert_retrace_int_o          (vert_retrace_int_o),
        .sprite_large_o              (sprite_large_o),
        .sprite_enlarged_o           (sprite_enlarged_o),
        .text_color_o                (text_color_o),
        .back_color_o                (back_color_o)
    );

endmodule
